// File: rtl/bus_arb_pkg.sv
// Shared types for the two-requester bus arbiter: FSM states, counter width
// and the encoding of a grant index.
package bus_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam int CNT_W = 4;

   typedef enum logic {
      GRANT_0 = 1'b0,
      GRANT_1 = 1'b1
   } grant_t;

endpackage

// File: rtl/bus_arb_rr_pick.sv
// Combinational two-way round-robin select. On a tie the requester that did
// not win last time is chosen.
module rr_pick
   import bus_arb_pkg::*;
(
   input  logic   i_req0,
   input  logic   i_req1,
   input  grant_t i_last_grant,
   output logic   o_grant_valid,
   output grant_t o_grant_idx
);

   always_comb begin
      o_grant_valid = i_req0 | i_req1;
      if (i_req0 && i_req1) begin
         o_grant_idx = (i_last_grant == GRANT_0) ? GRANT_1 : GRANT_0;
      end else if (i_req1) begin
         o_grant_idx = GRANT_1;
      end else begin
         o_grant_idx = GRANT_0;
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Shares one external data bus between the CPU memory stage (port 0) and a
// DMA/debug master (port 1) with fixed-length accesses and a one-cycle ack.
module bus_arbiter
   import bus_arb_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int WAIT_STATES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req0,
   input  logic              i_we0,
   input  logic [ADDR_W-1:0] i_addr0,
   input  logic [DATA_W-1:0] i_wdata0,
   output logic              o_ack0,
   input  logic              i_req1,
   input  logic              i_we1,
   input  logic [ADDR_W-1:0] i_addr1,
   input  logic [DATA_W-1:0] i_wdata1,
   output logic              o_ack1,
   output logic [DATA_W-1:0] o_rdata,
   output logic              o_busy,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_cs,
   output logic              o_wr_rd,
   output logic [DATA_W-1:0] o_data_bus_write,
   input  logic [DATA_W-1:0] i_data_bus_read
);

   state_t             r_state,   w_state_nxt;
   logic [CNT_W-1:0]   r_cnt,     w_cnt_nxt;
   grant_t             r_last,    w_last_nxt;
   logic [ADDR_W-1:0]  r_addr,    w_addr_nxt;
   logic [DATA_W-1:0]  r_dbw,     w_dbw_nxt;
   logic [DATA_W-1:0]  r_rdata,   w_rdata_nxt;
   logic               r_cs,      w_cs_nxt;
   logic               r_wr_rd,   w_wr_rd_nxt;
   logic               r_ack0,    w_ack0_nxt;
   logic               r_ack1,    w_ack1_nxt;
   logic               r_busy,    w_busy_nxt;

   logic               w_grant_valid;
   grant_t             w_grant_idx;

   rr_pick u_rr_pick (
      .i_req0        (i_req0),
      .i_req1        (i_req1),
      .i_last_grant  (r_last),
      .o_grant_valid (w_grant_valid),
      .o_grant_idx   (w_grant_idx)
   );

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_last_nxt  = r_last;
      w_addr_nxt  = r_addr;
      w_dbw_nxt   = r_dbw;
      w_rdata_nxt = r_rdata;
      w_cs_nxt    = r_cs;
      w_wr_rd_nxt = r_wr_rd;
      w_ack0_nxt  = 1'b0;
      w_ack1_nxt  = 1'b0;

      unique case (r_state)
         IDLE: begin
            w_cs_nxt    = 1'b0;
            w_wr_rd_nxt = 1'b0;
            if (w_grant_valid) begin
               w_addr_nxt  = (w_grant_idx == GRANT_1) ? i_addr1  : i_addr0;
               w_wr_rd_nxt = (w_grant_idx == GRANT_1) ? i_we1    : i_we0;
               w_dbw_nxt   = (w_grant_idx == GRANT_1) ? i_wdata1 : i_wdata0;
               w_cs_nxt    = 1'b1;
               w_cnt_nxt   = CNT_W'(WAIT_STATES - 1);
               w_last_nxt  = w_grant_idx;
               w_state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            // Bus data is captured in the final cycle that cs is asserted.
            if (r_cnt == '0) begin
               if (!r_wr_rd) w_rdata_nxt = i_data_bus_read;
               w_cs_nxt    = 1'b0;
               w_wr_rd_nxt = 1'b0;
               w_ack0_nxt  = (r_last == GRANT_0);
               w_ack1_nxt  = (r_last == GRANT_1);
               w_state_nxt = DONE;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase

      w_busy_nxt = (w_state_nxt != IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_last  <= GRANT_1;
         r_addr  <= '0;
         r_dbw   <= '0;
         r_rdata <= '0;
         r_cs    <= 1'b0;
         r_wr_rd <= 1'b0;
         r_ack0  <= 1'b0;
         r_ack1  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_last  <= w_last_nxt;
         r_addr  <= w_addr_nxt;
         r_dbw   <= w_dbw_nxt;
         r_rdata <= w_rdata_nxt;
         r_cs    <= w_cs_nxt;
         r_wr_rd <= w_wr_rd_nxt;
         r_ack0  <= w_ack0_nxt;
         r_ack1  <= w_ack1_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   assign o_ack0           = r_ack0;
   assign o_ack1           = r_ack1;
   assign o_rdata          = r_rdata;
   assign o_busy           = r_busy;
   assign o_addr           = r_addr;
   assign o_cs             = r_cs;
   assign o_wr_rd          = r_wr_rd;
   assign o_data_bus_write = r_dbw;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a WAIT_STATES=2 instance and a WAIT_STATES=1
// instance, each with an ack scoreboard fed by the stimulus code.
module tb_bus_arbiter;

   typedef struct {
      bit          idx;
      logic [31:0] rdata;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   exp_t qa[$];
   exp_t qb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Instance A: WAIT_STATES = 2
   logic        a_req0 = 0, a_we0 = 0, a_req1 = 0, a_we1 = 0;
   logic [31:0] a_addr0 = 0, a_wdata0 = 0, a_addr1 = 0, a_wdata1 = 0, a_dbr = 0;
   logic        a_ack0, a_ack1, a_busy, a_cs, a_wr_rd;
   logic [31:0] a_rdata, a_addr, a_dbw;

   bus_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_STATES(2)) u_dut_a (
      .clk(clk), .rst(rst),
      .i_req0(a_req0), .i_we0(a_we0), .i_addr0(a_addr0), .i_wdata0(a_wdata0), .o_ack0(a_ack0),
      .i_req1(a_req1), .i_we1(a_we1), .i_addr1(a_addr1), .i_wdata1(a_wdata1), .o_ack1(a_ack1),
      .o_rdata(a_rdata), .o_busy(a_busy), .o_addr(a_addr), .o_cs(a_cs), .o_wr_rd(a_wr_rd),
      .o_data_bus_write(a_dbw), .i_data_bus_read(a_dbr)
   );

   // Instance B: WAIT_STATES = 1
   logic        b_req0 = 0, b_we0 = 0, b_req1 = 0, b_we1 = 0;
   logic [31:0] b_addr0 = 0, b_wdata0 = 0, b_addr1 = 0, b_wdata1 = 0, b_dbr = 0;
   logic        b_ack0, b_ack1, b_busy, b_cs, b_wr_rd;
   logic [31:0] b_rdata, b_addr, b_dbw;

   bus_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_STATES(1)) u_dut_b (
      .clk(clk), .rst(rst),
      .i_req0(b_req0), .i_we0(b_we0), .i_addr0(b_addr0), .i_wdata0(b_wdata0), .o_ack0(b_ack0),
      .i_req1(b_req1), .i_we1(b_we1), .i_addr1(b_addr1), .i_wdata1(b_wdata1), .o_ack1(b_ack1),
      .o_rdata(b_rdata), .o_busy(b_busy), .o_addr(b_addr), .o_cs(b_cs), .o_wr_rd(b_wr_rd),
      .o_data_bus_write(b_dbw), .i_data_bus_read(b_dbr)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   // Move to just after the next rising edge; cyc then names the current cycle.
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic exp_t mk(input bit idx, input logic [31:0] rd, input int c);
      exp_t e;
      e.idx = idx;
      e.rdata = rd;
      e.cyc = c;
      return e;
   endfunction

   // Scoreboard monitors: any ack pops one expectation.
   always begin
      @(posedge clk);
      #2;
      if (!rst && (a_ack0 || a_ack1)) begin
         check("a_ack_exclusive", {a_ack0, a_ack1} == 2'b11, 1'b0);
         if (qa.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL a_unexpected_ack @cyc %0d: ack0=%0b ack1=%0b, none expected", cyc, a_ack0, a_ack1);
         end else begin
            exp_t e;
            e = qa.pop_front();
            check("a_ack_idx", a_ack1, e.idx);
            check("a_ack_cycle", cyc, e.cyc);
            check("a_ack_rdata", a_rdata, e.rdata);
         end
      end
   end

   always begin
      @(posedge clk);
      #2;
      if (!rst && (b_ack0 || b_ack1)) begin
         if (qb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL b_unexpected_ack @cyc %0d: ack0=%0b ack1=%0b, none expected", cyc, b_ack0, b_ack1);
         end else begin
            exp_t e;
            e = qb.pop_front();
            check("b_ack_idx", b_ack1, e.idx);
            check("b_ack_cycle", cyc, e.cyc);
            check("b_ack_rdata", b_rdata, e.rdata);
         end
      end
   end

   initial begin
      int t;

      // Reset state
      tick(2);
      check("rst_cs", a_cs, 0);
      check("rst_busy", a_busy, 0);
      check("rst_acks", {a_ack0, a_ack1}, 0);
      check("rst_addr", a_addr, 0);
      check("rst_rdata", a_rdata, 0);
      check("rst_wr_rd", a_wr_rd, 0);
      check("rst_dbw", a_dbw, 0);
      check("rst_b_cs", b_cs, 0);
      rst = 1'b0;
      tick();

      // Single read on port 0
      t = cyc;
      a_req0 = 1; a_we0 = 0; a_addr0 = 32'h100; a_dbr = 32'hDEADBEEF;
      qa.push_back(mk(0, 32'hDEADBEEF, t + 3));
      check("rd_idle_cs", a_cs, 0);
      for (int i = 1; i <= 2; i++) begin
         tick();
         check("rd_cs", a_cs, 1);
         check("rd_addr", a_addr, 32'h100);
         check("rd_wr_rd", a_wr_rd, 0);
         check("rd_busy", a_busy, 1);
      end
      tick();
      check("rd_cs_off", a_cs, 0);
      tick();
      a_req0 = 0;
      check("rd_busy_low", a_busy, 0);
      check("rd_rdata_held", a_rdata, 32'hDEADBEEF);

      // Single write on port 1; bus read data changes but must not reach rdata
      t = cyc;
      a_req1 = 1; a_we1 = 1; a_addr1 = 32'h2000_0004; a_wdata1 = 32'h12345678; a_dbr = 32'hCAFEF00D;
      qa.push_back(mk(1, 32'hDEADBEEF, t + 3));
      for (int i = 1; i <= 2; i++) begin
         tick();
         check("wr_cs", a_cs, 1);
         check("wr_wr_rd", a_wr_rd, 1);
         check("wr_addr", a_addr, 32'h2000_0004);
         check("wr_dbw", a_dbw, 32'h12345678);
      end
      tick(2);
      a_req1 = 0; a_we1 = 0;
      check("wr_rdata_unchanged", a_rdata, 32'hDEADBEEF);

      // Tie right after reset: port 0 first, then port 1
      rst = 1; tick(2); rst = 0; tick();
      t = cyc;
      a_req0 = 1; a_we0 = 0; a_addr0 = 32'h10;
      a_req1 = 1; a_we1 = 0; a_addr1 = 32'h20;
      a_dbr = 32'h1111_1111;
      qa.push_back(mk(0, 32'h1111_1111, t + 3));
      qa.push_back(mk(1, 32'h2222_2222, t + 7));
      tick();
      check("tie_first_addr", a_addr, 32'h10);
      tick(3);
      a_req0 = 0; a_dbr = 32'h2222_2222;
      tick();
      check("tie_second_addr", a_addr, 32'h20);
      tick(3);
      a_req1 = 0;

      // Continuous contention: 0 reads, 1 writes, six accesses alternating
      t = cyc;
      a_req0 = 1; a_we0 = 0; a_addr0 = 32'h40; a_dbr = 32'h5A5A_5A5A;
      a_req1 = 1; a_we1 = 1; a_addr1 = 32'h80; a_wdata1 = 32'hA5A5_A5A5;
      for (int k = 0; k < 6; k++)
         qa.push_back(mk(k[0], 32'h5A5A_5A5A, t + 3 + 4 * k));
      tick(24);
      a_req0 = 0; a_req1 = 0; a_we1 = 0;

      // Reset during the second ACCESS cycle of a read
      tick();
      a_req0 = 1; a_we0 = 0; a_addr0 = 32'h300; a_dbr = 32'h7777_7777;
      tick(2);
      check("abort_cs_before", a_cs, 1);
      rst = 1; a_req0 = 0;
      tick();
      check("abort_cs", a_cs, 0);
      check("abort_busy", a_busy, 0);
      check("abort_no_ack", {a_ack0, a_ack1}, 0);
      check("abort_rdata", a_rdata, 0);
      rst = 0;
      t = cyc;
      a_req0 = 1; a_addr0 = 32'h304; a_dbr = 32'h8888_8888;
      qa.push_back(mk(0, 32'h8888_8888, t + 3));
      tick(4);
      a_req0 = 0;

      // WAIT_STATES=1 instance: single read, input change after grant ignored
      tick();
      t = cyc;
      b_req0 = 1; b_we0 = 0; b_addr0 = 32'h400; b_dbr = 32'h9999_9999;
      qb.push_back(mk(0, 32'h9999_9999, t + 2));
      tick();
      check("b_cs_on", b_cs, 1);
      check("b_addr", b_addr, 32'h400);
      b_addr0 = 32'hFFF;
      tick();
      check("b_cs_one_cycle", b_cs, 0);
      check("b_addr_held", b_addr, 32'h400);
      tick();
      b_req0 = 0;
      check("b_busy_low", b_busy, 0);
      check("b_addr_still", b_addr, 32'h400);

      // Every expected ack must have arrived
      tick(4);
      check("a_queue_drained", qa.size(), 0);
      check("b_queue_drained", qb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
